writeback_buffer: RTL

- Posted write buffer between the data cache and single-port main memory.
- Accepts whole dirty 256-bit lines evicted by the cache, queues them in FIFO order, and drains each one to memory as a burst of 32-bit word beats.
- The cache can refill without waiting for the writeback to finish.
- Provides an address lookup port so a refill miss never reads stale memory data.

---
 rtl/otter_mem_pkg.sv | 35 +++
 rtl/wb_match.sv | 40 ++++
 rtl/writeback_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/otter_mem_pkg.sv
// Shared memory-subsystem types for the posted writeback buffer.
// Line geometry, the buffer entry layout, the drain FSM state type and a
// small helper that extracts one memory word from a cache line.
package otter_mem_pkg;

  localparam int LINE_BITS   = 256;
  localparam int WORD_BITS   = 32;
  localparam int BEATS       = LINE_BITS / WORD_BITS;
  localparam int ADDR_BITS   = 32;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int TAG_BITS    = ADDR_BITS - OFFSET_BITS;
  localparam int BEAT_W      = $clog2(BEATS);

  typedef logic [LINE_BITS-1:0] line_t;
  typedef logic [TAG_BITS-1:0]  tag_t;

  typedef struct packed {
    logic  valid;
    tag_t  tag;
    line_t data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_BURST,
    WB_GAP
  } wb_state_t;

  // Word 0 of a line sits in the least significant bits.
  function automatic logic [WORD_BITS-1:0] line_word(input line_t line,
                                                     input logic [BEAT_W-1:0] beat);
    return line[int'(beat)*WORD_BITS +: WORD_BITS];
  endfunction

endpackage

// File: rtl/wb_match.sv
// Youngest-match priority selector for the writeback buffer lookup port.
// Every valid entry whose tag equals the lookup tag is a candidate; the one
// written most recently (closest behind the write pointer) wins.
module wb_match
  import otter_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  tag_t             tags [DEPTH],
  input  tag_t             lookup_tag,
  input  logic [PTR_W-1:0] wr_ptr,
  output logic             hit,
  output logic [PTR_W-1:0] idx
);

  logic [DEPTH-1:0] match;
  logic [PTR_W-1:0] pos;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
    assign match[gi] = valid[gi] && (tags[gi] == lookup_tag);
  end

  // Walk from oldest slot (wr_ptr - DEPTH) to youngest (wr_ptr - 1) so the
  // last match seen, i.e. the youngest, overrides older ones.
  always_comb begin
    hit = 1'b0;
    idx = wr_ptr;
    pos = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      pos = wr_ptr - PTR_W'(k);
      if (match[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Posted writeback buffer between the data cache and single-port memory.
// Whole dirty lines are queued in FIFO order and drained as 32-bit beat
// bursts; a line-granular lookup port flags misses that hit a queued line.
// Build option: define WB_FORWARD_EN to expose lookup_data, the youngest
// matching queued line, so the cache can refill straight from the buffer.
module writeback_buffer
  import otter_mem_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   evict_valid,
  output logic                   evict_ready,
  input  logic [ADDR_BITS-1:0]   evict_addr,
  input  line_t                  evict_data,
  output logic                   mem_req,
  output logic [ADDR_BITS-1:0]   mem_addr,
  output logic [WORD_BITS-1:0]   mem_wdata,
  input  logic                   mem_beat_ack,
  input  logic [ADDR_BITS-1:0]   lookup_addr,
  output logic                   lookup_hit,
`ifdef WB_FORWARD_EN
  output line_t                  lookup_data,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t             entries_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  wb_state_t             state_reg;
  wb_state_t             state_next;
  logic [BEAT_W-1:0]     beat_reg;
  logic [BEAT_W-1:0]     beat_next;
  line_t                 head_data_reg;
  logic [ADDR_BITS-1:0]  mem_addr_reg;
  logic [WORD_BITS-1:0]  mem_wdata_reg;

  logic                  push;
  logic                  pop;
  logic                  load_head;
  logic                  advance;

  logic [DEPTH-1:0]      valid_vec;
  tag_t                  tag_arr [DEPTH];
  tag_t                  lookup_tag;
  logic [PTR_W-1:0]      match_idx;

  // Offset bits inside a line never take part in matching or storage.
  logic                  unused_offset_bits;
  assign unused_offset_bits = ^{evict_addr[OFFSET_BITS-1:0], lookup_addr[OFFSET_BITS-1:0]};

  // Readiness comes from the registered count only, so a pop in the same
  // cycle cannot open a slot for a push when the buffer is full.
  assign evict_ready = (count_reg < CNT_W'(DEPTH));
  assign push        = evict_valid && evict_ready;
  assign count       = count_reg;
  assign empty       = (count_reg == '0);
  assign beat_next   = beat_reg + BEAT_W'(1);

  assign mem_req     = (state_reg == WB_BURST);
  assign mem_addr    = mem_addr_reg;
  assign mem_wdata   = mem_wdata_reg;

  // State register for the drain FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= WB_IDLE;
    else        state_reg <= state_next;
  end

  // Drain sequencing: start a burst on a non-empty queue, step beats on
  // ack, pop on the final beat and force one idle gap cycle between bursts.
  always_comb begin
    state_next = state_reg;
    load_head  = 1'b0;
    advance    = 1'b0;
    pop        = 1'b0;
    case (state_reg)
      WB_IDLE: begin
        if (count_reg != '0) begin
          state_next = WB_BURST;
          load_head  = 1'b1;
        end
      end
      WB_BURST: begin
        if (mem_beat_ack) begin
          if (beat_reg == BEAT_W'(BEATS - 1)) begin
            pop        = 1'b1;
            state_next = WB_GAP;
          end else begin
            advance = 1'b1;
          end
        end
      end
      WB_GAP:  state_next = WB_IDLE;
      default: state_next = WB_IDLE;
    endcase
  end

  // Entry storage: write at the tail on push, invalidate the head on pop.
  // Push and pop never hit the same slot because a full buffer refuses pushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) entries_reg[i] <= '0;
    end else begin
      if (pop) entries_reg[rd_ptr_reg].valid <= 1'b0;
      if (push) begin
        entries_reg[wr_ptr_reg] <= '{valid: 1'b1,
                                     tag:   evict_addr[ADDR_BITS-1:OFFSET_BITS],
                                     data:  evict_data};
      end
    end
  end

  // Pointers wrap naturally at DEPTH; count tells full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Beat datapath: the head line is copied at burst start so address and
  // data stay stable until each beat is acknowledged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_reg      <= '0;
      head_data_reg <= '0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else if (load_head) begin
      beat_reg      <= '0;
      head_data_reg <= entries_reg[rd_ptr_reg].data;
      mem_addr_reg  <= {entries_reg[rd_ptr_reg].tag, {OFFSET_BITS{1'b0}}};
      mem_wdata_reg <= line_word(entries_reg[rd_ptr_reg].data, '0);
    end else if (advance) begin
      beat_reg      <= beat_next;
      mem_addr_reg  <= mem_addr_reg + ADDR_BITS'(WORD_BITS / 8);
      mem_wdata_reg <= line_word(head_data_reg, beat_next);
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_view
    assign valid_vec[gi] = entries_reg[gi].valid;
    assign tag_arr[gi]   = entries_reg[gi].tag;
  end

  assign lookup_tag = lookup_addr[ADDR_BITS-1:OFFSET_BITS];

  wb_match #(
    .DEPTH (DEPTH)
  ) u_match (
    .valid      (valid_vec),
    .tags       (tag_arr),
    .lookup_tag (lookup_tag),
    .wr_ptr     (wr_ptr_reg),
    .hit        (lookup_hit),
    .idx        (match_idx)
  );

`ifdef WB_FORWARD_EN
  assign lookup_data = entries_reg[match_idx].data;
`else
  logic unused_match_idx;
  assign unused_match_idx = ^match_idx;
`endif

endmodule
